uart_cmd_rx: RTL and testbench



---
 rtl/uart_cmd_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver and 4-byte command-frame parser (sync 0xFF, cmd, value, checksum).
// Received bytes feed the parser. Validated commands come out as single-cycle pulses
// with the command code and value held until the next command.
module uart_cmd_rx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DIVISOR   = CLK_FREQ / BAUD_RATE,
  parameter int unsigned HALF_DIV  = DIVISOR / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic [5:0] cmd_value,
  output logic       cmd_err
);

  localparam int unsigned CNT_W = ($clog2(DIVISOR) > 14) ? $clog2(DIVISOR) : 14;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} r_state_t;
  typedef enum logic [1:0] {P_SYNC, P_CMD, P_VAL, P_CHK} p_state_t;

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       sync_fill;
  logic             armed;
  logic             fall;
  r_state_t         r_state, r_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_tick, stop_ok, stop_bad;
  logic             at_full, at_half;
  p_state_t         p_state, p_next;
  logic [3:0]       cmd_q;
  logic [7:0]       val_q;
  logic [5:0]       limit;
  logic             chk_pass, chk_fail, cmd_bad;

  // Synchroniser, edge-history register and start-detect arming.
  // The flops reset high, so a line held low at release would look like a falling
  // edge. Start detection stays disarmed until a real synchronised high is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= '0;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_sync) armed <= 1'b1;
    end
  end

  assign fall    = armed & rx_prev & ~rx_sync;
  assign at_full = (cnt == FULL_CNT);
  assign at_half = (cnt == HALF_CNT);

  // Receiver next-state logic and per-cycle strobes.
  always_comb begin
    r_next   = r_state;
    bit_tick = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (r_state)
      R_IDLE:   if (fall) r_next = R_START;
      R_START:  if (at_half) r_next = rx_sync ? R_IDLE : R_DATA;
      R_DATA: begin
        if (at_full) begin
          bit_tick = 1'b1;
          if (bit_idx == 3'd7) r_next = R_STOP;
        end
      end
      R_STOP: begin
        if (at_full) begin
          if (rx_sync) begin
            stop_ok = 1'b1;
            r_next  = R_IDLE;
          end else begin
            stop_bad = 1'b1;
            r_next   = R_WAITHI;
          end
        end
      end
      R_WAITHI: if (rx_sync) r_next = R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  // Receiver state, bit timer, shift register and byte outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_state <= r_next;
      if (r_next != r_state || bit_tick || r_state == R_IDLE || r_state == R_WAITHI)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (r_state == R_IDLE && fall) bit_idx <= '0;
      else if (bit_tick)             bit_idx <= bit_idx + 1'b1;
      if (bit_tick) shreg <= {rx_sync, shreg[7:1]};
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
      if (stop_ok) rx_data <= shreg;
    end
  end

  // Upper bound of the command value for each code.
  always_comb begin
    limit = 6'd0;
    case (cmd_q)
      4'd1, 4'd4:             limit = 6'd23;
      4'd2, 4'd3, 4'd5, 4'd6: limit = 6'd59;
      4'd7:                   limit = 6'd7;
      4'd8:                   limit = 6'd1;
      default:                limit = 6'd0;
    endcase
  end

  // Parser next-state logic. The parser advances only on received bytes, and a framing error resynchronises it.
  always_comb begin
    p_next   = p_state;
    chk_pass = 1'b0;
    chk_fail = 1'b0;
    cmd_bad  = 1'b0;
    if (frame_err) begin
      p_next = P_SYNC;
    end else if (rx_valid) begin
      case (p_state)
        P_SYNC: if (rx_data == 8'hFF) p_next = P_CMD;
        P_CMD: begin
          if (rx_data == 8'hFF) begin
            p_next = P_CMD;
          end else if (rx_data[7:4] == 4'h0 && rx_data[3:0] >= 4'd1 && rx_data[3:0] <= 4'd8) begin
            p_next = P_VAL;
          end else begin
            cmd_bad = 1'b1;
            p_next  = P_SYNC;
          end
        end
        P_VAL: p_next = P_CHK;
        P_CHK: begin
          p_next = P_SYNC;
          if (rx_data == ({4'h0, cmd_q} ^ val_q) && val_q[7:6] == 2'b00 && val_q[5:0] <= limit)
            chk_pass = 1'b1;
          else
            chk_fail = 1'b1;
        end
        default: p_next = P_SYNC;
      endcase
    end
  end

  // Parser state, field latches and command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state   <= P_SYNC;
      cmd_q     <= '0;
      val_q     <= '0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_code  <= '0;
      cmd_value <= '0;
    end else begin
      p_state <= p_next;
      if (p_state == P_CMD && p_next == P_VAL) cmd_q <= rx_data[3:0];
      if (p_state == P_VAL && p_next == P_CHK) val_q <= rx_data;
      cmd_valid <= chk_pass;
      cmd_err   <= chk_fail | cmd_bad;
      if (chk_pass) begin
        cmd_code  <= cmd_q;
        cmd_value <= val_q[5:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios plus randomized frames checked against a frame-level rule model.
module tb_uart_cmd_rx;

  localparam int unsigned D   = 16;  // clocks per bit with the overrides below
  localparam int unsigned H   = 8;
  localparam int unsigned LAT = (D * 19) / 2 + 3;
  localparam int          EV_ERR = 32'h2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, cmd_valid, cmd_err;
  logic [3:0] cmd_code;
  logic [5:0] cmd_value;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] rx_q[$];
  int         ev_q[$];
  int         fe_cnt = 0;
  int         both_cnt = 0;
  time        t_start, t_rxv;

  uart_cmd_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_value(cmd_value), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Record every pulse away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        t_rxv = $time;
      end
      if (frame_err) fe_cnt++;
      if (cmd_valid) ev_q.push_back(32'h1000 | (int'(cmd_code) << 8) | int'(cmd_value));
      if (cmd_err) ev_q.push_back(EV_ERR);
      if (cmd_valid && cmd_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int ev_v(input int code, input int val);
    return 32'h1000 | (code << 8) | val;
  endfunction

  function automatic int lim(input int code);
    case (code)
      1, 4:       return 23;
      2, 3, 5, 6: return 59;
      7:          return 7;
      8:          return 1;
      default:    return -1;
    endcase
  endfunction

  // Outcome of a complete frame with an in-range code, straight from the acceptance rules.
  function automatic int frame_outcome(input int code, input int val, input int chk);
    if (chk != (code ^ val)) return EV_ERR;
    if (val > lim(code))     return EV_ERR;
    return ev_v(code, val);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    t_start = $time;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(negedge clk);
    end
    rx = stop;
    repeat (D) @(negedge clk);
    if (stop) rx = 1'b1;
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * D) @(negedge clk);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    ev_q.delete();
    fe_cnt = 0;
  endtask

  task automatic cmp_events(input string tag, input int exp[$]);
    check({tag, "_n"}, ev_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ev_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), ev_q[i], exp[i]);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
  endtask

  initial begin
    int exp[$];
    int lat;
    logic [7:0] fr[$];

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_outs", {rx_data, cmd_code, cmd_value, rx_valid, frame_err, cmd_valid, cmd_err}, 0);
    rst_n = 1'b1;
    idle(3);

    // Single byte and its latency from the start edge
    send_byte(8'h35, 1'b1);
    idle(2);
    check("b35_n", rx_q.size(), 1);
    if (rx_q.size() > 0) check("b35_d", rx_q[0], 8'h35);
    lat = int'((t_rxv - t_start) / 10);
    check("b35_lat", (lat >= int'(LAT) - 3 && lat <= int'(LAT) + 3) ? LAT : lat, LAT);
    clear_mon();

    // Glitch shorter than half a bit, then a real byte
    rx = 1'b0;
    repeat (H / 2) @(negedge clk);
    idle(2);
    check("glitch_rx", rx_q.size(), 0);
    check("glitch_fe", fe_cnt, 0);
    send_byte(8'hA5, 1'b1);
    idle(2);
    check("a5_n", rx_q.size(), 1);
    check("a5_d", rx_data, 8'hA5);
    clear_mon();

    // Stop bit low: framing error, data unchanged, recovery after line returns high
    send_byte(8'h5A, 1'b0);
    repeat (2 * D) @(negedge clk);
    idle(2);
    check("fe_cnt", fe_cnt, 1);
    check("fe_norx", rx_q.size(), 0);
    check("fe_hold", rx_data, 8'hA5);
    send_byte(8'h12, 1'b1);
    idle(2);
    check("b12_n", rx_q.size(), 1);
    check("b12_d", rx_data, 8'h12);
    clear_mon();

    // Directed frames
    fr = '{8'hFF, 8'h01, 8'h17, 8'h16, 8'hFF, 8'hFF, 8'h08, 8'h01, 8'h09,
           8'hFF, 8'h02, 8'h3C, 8'h3E, 8'hFF, 8'h03, 8'h10, 8'h12, 8'hFF, 8'h09};
    send_frame(fr);
    idle(2);
    exp = '{ev_v(1, 23), ev_v(8, 1), EV_ERR, EV_ERR, EV_ERR};
    cmp_events("dir", exp);
    check("dir_code", cmd_code, 4'd8);
    check("dir_val", cmd_value, 6'd1);
    clear_mon();

    // A framing error mid-frame drops the frame without cmd_err
    send_frame('{8'hFF, 8'h01});
    send_byte(8'h5A, 1'b0);
    repeat (2 * D) @(negedge clk);
    idle(2);
    send_frame('{8'hFF, 8'h03, 8'h10, 8'h13});
    idle(2);
    exp = '{ev_v(3, 16)};
    cmp_events("fe_resync", exp);
    clear_mon();

    // Randomized frames against the rule model
    exp.delete();
    for (int f = 0; f < 40; f++) begin
      int r, code, val, chk, gap;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) send_byte(8'hFF, 1'b1);
      if (r == 0) begin
        do code = $urandom_range(0, 255); while ((code >= 1 && code <= 8) || code == 255);
        send_frame('{8'hFF, 8'(code)});
        exp.push_back(EV_ERR);
      end else begin
        code = $urandom_range(1, 8);
        if (r <= 3) val = $urandom_range(0, 255);
        else        val = $urandom_range(0, lim(code) + 1);
        chk = code ^ val;
        if (r == 9) chk = chk ^ (1 << $urandom_range(0, 7));
        send_byte(8'hFF, 1'b1);
        send_byte(8'(code), 1'b1);
        send_byte(8'(val), 1'b1);
        send_byte(8'(chk), 1'b1);
        exp.push_back(frame_outcome(code, val, chk));
      end
      gap = $urandom_range(0, D);
      repeat (gap) @(negedge clk);
    end
    idle(2);
    cmp_events("rnd", exp);
    check("rnd_fe", fe_cnt, 0);
    clear_mon();

    // Reset during bit 4 of the value byte, then the whole frame again
    send_frame('{8'hFF, 8'h05});
    fork
      send_byte(8'h2A, 1'b1);
      begin
        repeat (5 * D + D / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_outs", {rx_data, cmd_code, cmd_value, rx_valid, frame_err, cmd_valid, cmd_err}, 0);
        rst_n = 1'b1;
      end
    join
    idle(20);
    check("midrst_nocmd", ev_q.size(), 0);
    check("midrst_code", cmd_code, 4'd0);
    clear_mon();
    send_frame('{8'hFF, 8'h05, 8'h2A, 8'h2F});
    idle(2);
    exp = '{ev_v(5, 42)};
    cmp_events("resend", exp);
    check("resend_code", cmd_code, 4'd5);
    check("resend_val", cmd_value, 6'd42);

    check("excl", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
